// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers one processor request at a time
// with a fixed number of wait states, flagging misaligned/out-of-range/conflicting requests.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             opLegal;
  logic             opWrite;
  logic [IDX_W-1:0] opIdx;
  logic [31:0]      opData;
  logic [31:0]      storage [DEPTH_WORDS];

  logic             reqLegal;
  logic [IDX_W-1:0] reqIdx;
  logic             reqValid;

  // Full 30-bit index is compared, so addresses past the end never alias low words.
  assign reqLegal = (data_addr[1:0] == 2'b00)
                 && ({2'b00, data_addr[31:2]} < 32'(DEPTH_WORDS))
                 && !(mem_read && mem_write);
  assign reqIdx   = data_addr[IDX_W+1:2];
  assign reqValid = mem_read || mem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      busy      <= 1'b0;
      data_out  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          if (reqValid) begin
            opLegal <= reqLegal;
            opWrite <= mem_write;
            opIdx   <= reqIdx;
            opData  <= data_in;
            busy    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              mem_ready <= 1'b1;
              mem_err   <= !reqLegal;
              if (reqLegal && !mem_write)
                data_out <= storage[reqIdx];
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_err   <= !opLegal;
            if (opLegal && !opWrite)
              data_out <= storage[opIdx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit on the edge leaving RESP; a reset on that edge drops the write.
  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && opLegal && opWrite)
      storage[opIdx] <= opData;
  end

endmodule
